// File: rtl/read_wait_responder.sv
// Target-side read responder: holds ws for a programmable wait count, then returns registered data.
// Latency: wait_cfg+1 cycles from rd rise to rvalid; every output is driven straight from a flop.
module read_wait_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ws,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              abort,
  output logic [7:0]        txn_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage lives in the same flop block so reset clears it and reads see the pre-write word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ws      <= 1'b0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      abort   <= 1'b0;
      txn_cnt <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      abort <= 1'b0;
      if (wr_en) mem[wr_addr] <= wr_data;

      case (state)
        S_IDLE: begin
          ws     <= 1'b0;
          rvalid <= 1'b0;
          if (rd) begin
            addr_q <= addr;
            if (wait_cfg == '0) begin
              rdata  <= mem[addr];
              rvalid <= 1'b1;
              state  <= S_DATA;
            end else begin
              cnt   <= wait_cfg;
              ws    <= 1'b1;
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!rd) begin
            ws     <= 1'b0;
            rvalid <= 1'b0;
            abort  <= 1'b1;
            state  <= S_IDLE;
          end else if (cnt > WAIT_W'(1)) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            rdata  <= mem[addr_q];
            rvalid <= 1'b1;
            ws     <= 1'b0;
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          ws <= 1'b0;
          if (!rd) begin
            rvalid  <= 1'b0;
            txn_cnt <= txn_cnt + 8'd1;
            state   <= S_IDLE;
          end else begin
            rvalid <= 1'b1;
          end
        end

        default: begin
          ws     <= 1'b0;
          rvalid <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_wait_responder.sv
// Bench for read_wait_responder: scoreboard of expected read words, popped when rvalid appears.
module tb_read_wait_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rd = 1'b0;
  logic [3:0] addr = '0;
  logic [3:0] wait_cfg = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       ws;
  logic [7:0] rdata;
  logic       rvalid;
  logic       abort;
  logic [7:0] txn_cnt;

  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] exp_txn = '0;
  int n_checks = 0;
  int n_pass = 0;

  read_wait_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .addr(addr), .wait_cfg(wait_cfg),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ws(ws), .rdata(rdata), .rvalid(rvalid), .abort(abort), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Full read handshake; optionally scrambles addr/wait_cfg during WAIT or writes on the capture edge.
  task automatic do_read(input logic [3:0] a, input logic [3:0] w, input bit scramble,
                         input bit wr_cap, input logic [7:0] wr_d, input string tag);
    int ws_cycles;
    bit done;
    logic [7:0] exp;
    exp_q.push_back(model[a]);
    rd = 1'b1; addr = a; wait_cfg = w;
    tick();
    ws_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rvalid) begin done = 1'b1; break; end
      if (ws) ws_cycles++;
      if (scramble) begin addr = ~a; wait_cfg = 4'd1; end
      if (wr_cap && ws_cycles == int'(w)) begin wr_en = 1'b1; wr_addr = a; wr_data = wr_d; end
      tick();
      if (wr_en) begin wr_en = 1'b0; model[a] = wr_d; end
    end
    n_checks++;
    if (!done) $display("FAIL %s rvalid_timeout: rvalid=%b, required 1 within 40 cycles", tag, rvalid);
    else n_pass++;
    n_checks++;
    if (ws_cycles !== int'(w)) $display("FAIL %s ws_cycles: got %0d, required %0d", tag, ws_cycles, w);
    else n_pass++;
    n_checks++;
    if (ws !== 1'b0) $display("FAIL %s ws_at_data: got %b, required 0", tag, ws);
    else n_pass++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (rdata !== exp) $display("FAIL %s rdata: got %h, required %h", tag, rdata, exp);
    else n_pass++;
    rd = 1'b0;
    tick();
    exp_txn = exp_txn + 8'd1;
    n_checks++;
    if (rvalid !== 1'b0) $display("FAIL %s rvalid_drop: got %b, required 0", tag, rvalid);
    else n_pass++;
    n_checks++;
    if (txn_cnt !== exp_txn) $display("FAIL %s txn_cnt: got %0d, required %0d", tag, txn_cnt, exp_txn);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    #3;
    n_checks++;
    if ({ws, rvalid, abort} !== 3'b000) $display("FAIL reset_flags: ws/rvalid/abort=%b, required 000", {ws, rvalid, abort});
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00 || txn_cnt !== 8'h00) $display("FAIL reset_regs: rdata=%h txn_cnt=%0d, required 00/0", rdata, txn_cnt);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    do_write(4'd3, 8'hA5);
    do_read(4'd3, 4'd0, 1'b0, 1'b0, 8'h00, "zero_wait");
  endtask

  task automatic test_wait_states();
    do_write(4'd7, 8'h3C);
    do_read(4'd7, 4'd3, 1'b0, 1'b0, 8'h00, "wait3");
  endtask

  task automatic test_abort();
    logic [7:0] txn_before;
    txn_before = txn_cnt;
    rd = 1'b1; addr = 4'd7; wait_cfg = 4'd5;
    tick();
    tick();
    n_checks++;
    if (ws !== 1'b1 || rvalid !== 1'b0) $display("FAIL abort_waiting: ws=%b rvalid=%b, required 1/0", ws, rvalid);
    else n_pass++;
    rd = 1'b0;
    tick();
    n_checks++;
    if ({ws, rvalid, abort} !== 3'b001) $display("FAIL abort_pulse: ws/rvalid/abort=%b, required 001", {ws, rvalid, abort});
    else n_pass++;
    tick();
    n_checks++;
    if (abort !== 1'b0 || rvalid !== 1'b0) $display("FAIL abort_one_cycle: abort=%b rvalid=%b, required 0/0", abort, rvalid);
    else n_pass++;
    n_checks++;
    if (txn_cnt !== txn_before) $display("FAIL abort_txn: got %0d, required %0d", txn_cnt, txn_before);
    else n_pass++;
  endtask

  task automatic test_read_before_write();
    do_write(4'd4, 8'h11);
    do_read(4'd4, 4'd2, 1'b0, 1'b1, 8'h22, "rbw_old");
    do_read(4'd4, 4'd0, 1'b0, 1'b0, 8'h00, "rbw_new");
  endtask

  task automatic test_scramble();
    do_write(4'd8, 8'h5A);
    do_write(4'd7, 8'hC3);
    do_read(4'd8, 4'd3, 1'b1, 1'b0, 8'h00, "scramble");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 13 + 7));
    for (int i = 0; i < 256; i++) do_read(4'(i), 4'd0, 1'b0, 1'b0, 8'h00, "b2b");
  endtask

  task automatic test_reset_mid();
    rd = 1'b1; addr = 4'd3; wait_cfg = 4'd5;
    tick();
    tick();
    n_checks++;
    if (ws !== 1'b1) $display("FAIL midrst_pre_ws: got %b, required 1", ws);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ws, rvalid, abort} !== 3'b000) $display("FAIL midrst_flags: ws/rvalid/abort=%b, required 000", {ws, rvalid, abort});
    else n_pass++;
    n_checks++;
    if (txn_cnt !== 8'h00) $display("FAIL midrst_txn: got %0d, required 0", txn_cnt);
    else n_pass++;
    rd = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    exp_txn = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    do_read(4'd3, 4'd0, 1'b0, 1'b0, 8'h00, "midrst_mem3");
    do_read(4'd9, 4'd1, 1'b0, 1'b0, 8'h00, "midrst_mem9");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_abort();
    test_read_before_write();
    test_scramble();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
